// File: rtl/reg_scoreboard_decoder_if.sv
// Issue/writeback/hazard bundle between issue logic and the register scoreboard.
// The master drives requests; the slave (scoreboard) returns status.
interface reg_scoreboard_decoder_if #(
  parameter int ADDR_W = 5
);
  localparam int NREG = 2**ADDR_W;

  logic              issue_valid;
  logic              issue_ready;
  logic [ADDR_W-1:0] issue_rd;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_rd;
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic              haz1;
  logic              haz2;
  logic [NREG-1:0]   pending;
  logic [NREG-1:0]   we_onehot;
  logic              err_underflow;
  logic              err_clr;

  modport master (
    output issue_valid, issue_rd, wb_valid, wb_rd, rs1, rs2, err_clr,
    input  issue_ready, haz1, haz2, pending, we_onehot, err_underflow
  );

  modport slave (
    input  issue_valid, issue_rd, wb_valid, wb_rd, rs1, rs2, err_clr,
    output issue_ready, haz1, haz2, pending, we_onehot, err_underflow
  );
endinterface

// File: rtl/reg_scoreboard_decoder.sv
// Register-file scoreboard: per-register outstanding-write counters, rs1/rs2
// hazard flags and a registered one-hot write-enable decoded from the WB address.

module reg_sb_slot #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             iss,
  input  logic             wb,
  output logic [CNT_W-1:0] cnt
);
  // iss is only ever asserted when cnt is below max, so no wrap is possible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        cnt <= '0;
    else if (iss && !wb)               cnt <= cnt + CNT_W'(1);
    else if (wb && !iss && cnt != '0)  cnt <= cnt - CNT_W'(1);
  end
endmodule

module reg_scoreboard_decoder #(
  parameter int ADDR_W             = 5,
  parameter int CNT_W              = 2,
  parameter bit ZERO_REG_HARDWIRED = 1'b1
) (
  input logic                     clk,
  input logic                     rst_n,
  reg_scoreboard_decoder_if.slave bus
);
  localparam int               NREG  = 2**ADDR_W;
  localparam logic [CNT_W-1:0] CMAX  = '1;
  // Bit 0 cleared when x0 is hardwired: it never counts, errors or write-enables.
  localparam logic [NREG-1:0]  TRACK = {{(NREG-1){1'b1}}, !ZERO_REG_HARDWIRED};

  logic [NREG-1:0][CNT_W-1:0] cnt;
  logic [NREG-1:0]            pend;
  logic [NREG-1:0]            iss_oh;
  logic [NREG-1:0]            wb_oh;
  logic                       issue_ready;
  logic                       underflow;
  logic                       err_q;
  logic [NREG-1:0]            we_q;

  function automatic logic [NREG-1:0] onehot(input logic [ADDR_W-1:0] a);
    logic [NREG-1:0] o;
    o = '0;
    for (int i = 0; i < NREG; i++) o[i] = (a == ADDR_W'(i));
    return o;
  endfunction

  // Ready looks only at state, so a same-cycle WB never relieves a full count.
  assign issue_ready = (cnt[bus.issue_rd] != CMAX);
  assign iss_oh      = onehot(bus.issue_rd) & TRACK & {NREG{bus.issue_valid && issue_ready}};
  assign wb_oh       = onehot(bus.wb_rd) & TRACK & {NREG{bus.wb_valid}};
  assign underflow   = |(wb_oh & ~pend);

  genvar g;
  generate
    for (g = 0; g < NREG; g++) begin : g_slot
      reg_sb_slot #(.CNT_W(CNT_W)) u_slot (
        .clk   (clk),
        .rst_n (rst_n),
        .iss   (iss_oh[g]),
        .wb    (wb_oh[g]),
        .cnt   (cnt[g])
      );
      assign pend[g] = |cnt[g];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q  <= '0;
      err_q <= 1'b0;
    end else begin
      we_q <= wb_oh;
      if (underflow)        err_q <= 1'b1;
      else if (bus.err_clr) err_q <= 1'b0;
    end
  end

  // A WB retiring the last outstanding write bypasses the hazard this cycle.
  assign bus.haz1 = pend[bus.rs1] &&
                    !(bus.wb_valid && bus.wb_rd == bus.rs1 && cnt[bus.rs1] == CNT_W'(1));
  assign bus.haz2 = pend[bus.rs2] &&
                    !(bus.wb_valid && bus.wb_rd == bus.rs2 && cnt[bus.rs2] == CNT_W'(1));

  assign bus.issue_ready   = issue_ready;
  assign bus.pending       = pend;
  assign bus.we_onehot     = we_q;
  assign bus.err_underflow = err_q;
endmodule
